// File: rtl/ro_pair_compare_counter_if.sv
// Request/result bundle between the challenge/response controller and the
// RO pair compare counter.
interface ro_pair_compare_counter_if #(
  parameter int CNT_W = 32,
  parameter int SEL_W = 3,
  parameter int WIN_W = 16
);
  logic             start;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic             done;
  logic             resp;
  logic             tie;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic             sat_a;
  logic             sat_b;

  modport master (
    output start, sel_a, sel_b, win_len,
    input  busy, done, resp, tie, count_a, count_b, sat_a, sat_b
  );

  modport slave (
    input  start, sel_a, sel_b, win_len,
    output busy, done, resp, tie, count_a, count_b, sat_a, sat_b
  );
endinterface

// File: rtl/ro_pair_compare_counter.sv
// Counts rising edges of two selected ring oscillators over a window of clk
// cycles and compares them to produce one PUF response bit.
//
// state   | meaning
// IDLE    | waiting for start, results held
// SETTLE  | 2 cycles flushing the synchronisers after a new selection
// MEASURE | win_len cycles of edge counting on both channels
// DONE    | 1 cycle, done pulse, resp/tie valid
module ro_pair_compare_counter #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ro_in,
  ro_pair_compare_counter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]          state;
  logic [NUM_CH-1:0]   s1, s2, s3;
  logic [NUM_CH-1:0]   ro_edge;
  logic [2**SEL_W-1:0] edge_pad;
  logic [SEL_W-1:0]    sel_a_q, sel_b_q;
  logic [WIN_W-1:0]    win_q, win_cnt;
  logic                settle_cnt;
  logic [CNT_W-1:0]    cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
  logic                sat_a, sat_b, sat_a_nxt, sat_b_nxt;
  logic                resp, tie;
  logic                edge_a, edge_b;

  assign ro_edge = s2 & ~s3;

  // Unused select codes map to a constant-0 channel, so they never count.
  always_comb begin
    edge_pad = '0;
    edge_pad[NUM_CH-1:0] = ro_edge;
  end

  assign edge_a = edge_pad[sel_a_q];
  assign edge_b = edge_pad[sel_b_q];

  always_comb begin
    cnt_a_nxt = cnt_a;
    sat_a_nxt = sat_a;
    cnt_b_nxt = cnt_b;
    sat_b_nxt = sat_b;
    if (state == MEASURE) begin
      if (edge_a) begin
        if (&cnt_a) sat_a_nxt = 1'b1;
        else        cnt_a_nxt = cnt_a + CNT_W'(1);
      end
      if (edge_b) begin
        if (&cnt_b) sat_b_nxt = 1'b1;
        else        cnt_b_nxt = cnt_b + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= 1'b0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      sat_a      <= 1'b0;
      sat_b      <= 1'b0;
      resp       <= 1'b0;
      tie        <= 1'b0;
    end else begin
      s1    <= ro_in;
      s2    <= s1;
      s3    <= s2;
      cnt_a <= cnt_a_nxt;
      cnt_b <= cnt_b_nxt;
      sat_a <= sat_a_nxt;
      sat_b <= sat_b_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SETTLE;
            sel_a_q    <= bus.sel_a;
            sel_b_q    <= bus.sel_b;
            win_q      <= bus.win_len;
            settle_cnt <= 1'b1;
            cnt_a      <= '0;
            cnt_b      <= '0;
            sat_a      <= 1'b0;
            sat_b      <= 1'b0;
            resp       <= 1'b0;
            tie        <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt) begin
            settle_cnt <= 1'b0;
          end else if (win_q == '0) begin
            state <= DONE;
            resp  <= cnt_a_nxt > cnt_b_nxt;
            tie   <= cnt_a_nxt == cnt_b_nxt;
          end else begin
            state   <= MEASURE;
            win_cnt <= win_q;
          end
        end
        MEASURE: begin
          // Results are taken from the next-state counts so the last window
          // cycle's edges are included in resp/tie.
          if (win_cnt == WIN_W'(1)) begin
            state <= DONE;
            resp  <= cnt_a_nxt > cnt_b_nxt;
            tie   <= cnt_a_nxt == cnt_b_nxt;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == SETTLE) || (state == MEASURE);
  assign bus.done    = (state == DONE);
  assign bus.resp    = resp;
  assign bus.tie     = tie;
  assign bus.count_a = cnt_a;
  assign bus.count_b = cnt_b;
  assign bus.sat_a   = sat_a;
  assign bus.sat_b   = sat_b;

endmodule

// File: doc/ro_pair_compare_counter.md
Name: ro_pair_compare_counter

Overview:
Parametrised successor to the single free-running PUF counter. It holds NUM_CH ring-oscillator inputs, selects two of them, and counts rising edges of each over a programmable window of clk cycles. At the end of the window it compares the two counts and produces one PUF response bit. It sits between the RO array and the challenge/response controller, with a start/busy/done handshake.

Parameters:
CNT_W, 32, width of each edge counter, and of count_a/count_b.
NUM_CH, 8, number of RO inputs.
SEL_W, 3, width of the channel select inputs; must satisfy 2^SEL_W >= NUM_CH.
WIN_W, 16, width of the measurement window length.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
ro_in  input  NUM_CH  raw RO outputs, asynchronous to clk.
start  input  1  request a measurement; sampled only in IDLE.
sel_a  input  SEL_W  channel A index; latched on start acceptance.
sel_b  input  SEL_W  channel B index; latched on start acceptance.
win_len  input  WIN_W  window length in clk cycles; latched on start acceptance.
busy  output  1  high while a measurement is in progress.
done  output  1  one-cycle pulse when results become valid.
resp  output  1  1 when count_a > count_b.
tie  output  1  1 when count_a == count_b.
count_a  output  CNT_W  edge count for channel A.
count_b  output  CNT_W  edge count for channel B.
sat_a  output  1  channel A counter saturated during the window.
sat_b  output  1  channel B counter saturated during the window.

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset values: all outputs 0, FSM in IDLE, synchroniser flops 0.
- Reset mid-operation: the measurement is aborted, no done pulse, all outputs return to 0.
- Synchronisation: each ro_in bit passes through a 2-flop synchroniser plus one history flop, running every cycle.
- Edge detection: edge[i] = s2[i] & ~s3[i].
- Out-of-range select: a latched select >= NUM_CH reads a constant-0 channel, which gives count 0.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - busy=0.
  - start=1 latches sel_a, sel_b and win_len, clears count_a/b, sat_a/b, resp and tie, loads a settle counter, and goes to SETTLE.
  - With start=0, all outputs hold their last values.
- SETTLE: 2 cycles, busy=1, no counting. This flushes the synchronisers after the selection changes.
- SETTLE exit: go to MEASURE with the window counter loaded to win_len. If win_len==0, go directly to DONE.
- MEASURE: busy=1, lasts exactly win_len cycles.
  - Each cycle, if the edge on channel A is set, count_a increments.
  - If count_a is already all-ones, it holds and sat_a is set; sat_a is sticky until the next start.
  - Channel B follows the same rule using count_b and sat_b.
  - A and B are evaluated independently in the same cycle.
- DONE: 1 cycle, busy=0, done=1.
  - resp and tie are registered from the final counts and are valid in the same cycle as done.
  - Next state is IDLE.
  - resp, tie, counts and sat flags then hold until the next accepted start.
- Timing: start accepted at the edge ending cycle T gives:
  - SETTLE in cycles T+1 and T+2;
  - MEASURE in cycles T+3 through T+2+W;
  - DONE in cycle T+3+W.
  - With W=0, DONE is in cycle T+3.
- start while busy or in DONE is ignored, with no queuing.
- start held continuously gives back-to-back measurements, one per W+4 cycles (IDLE, 2×SETTLE, W×MEASURE, DONE).
- sel_a == sel_b is legal and produces equal counts: tie=1, resp=0.
- Comparison is unsigned over the full CNT_W. Saturated counts compare as all-ones; both saturated gives tie=1.
- Input changes to sel_a, sel_b and win_len after acceptance have no effect.

Test Plan:
1. Count and compare: reset, then start with sel_a=0, sel_b=1, win_len=100; ro_in[0] toggles every 2 clk (period 4), ro_in[1] every 4 clk (period 8). Required: done in cycle T+103; count_a=25±1, count_b=12±1, resp=1, tie=0, busy low in DONE.
2. Saturation and equal select: build with CNT_W=4; sel_a=sel_b=2, win_len=200, ro_in[2] period 4. Required: count_a=count_b=15, sat_a=sat_b=1, tie=1, resp=0.
3. Zero window and out-of-range select: win_len=0 with active ROs → done in cycle T+3, counts 0, tie=1. Separately, sel_a=7 with NUM_CH=6 → count_a=0.
4. Handshake: pulse start again during MEASURE and during DONE, and change sel/win_len mid-run. Required: exactly one done, results match the original latched settings, outputs hold in IDLE.
5. Reset mid-MEASURE: assert reset asynchronously between clk edges. Required: all outputs 0 immediately, no done, a following start completes normally.
6. Back-to-back: hold start high with win_len=10. Required: done pulses spaced 14 cycles apart, counts cleared at each acceptance.
